// File: rtl/ym3438_pg_accum.sv
// YM3438 phase generator: forms a per-slot phase increment from the LFO-modulated fnum,
// block, detune and multiple, then updates a 24-slot time-multiplexed 20-bit phase accumulator.
module ym3438_pg_accum #(
    parameter int unsigned SLOTS   = 24,
    parameter int unsigned PHASE_W = 20
) (
    input  logic        MCLK,
    input  logic        IC,
    input  logic        slot_en,
    input  logic        sync,
    input  logic [11:0] fnum_lfo,
    input  logic [2:0]  block,
    input  logic [5:0]  dt_delta,
    input  logic [3:0]  multi,
    input  logic        kon,
    output logic [9:0]  phase_out,
    output logic [4:0]  out_slot,
    output logic        out_valid
);

    localparam int unsigned TAG_W   = 5;
    localparam int unsigned S1_W    = 17;
    localparam int unsigned SHIFT_W = 19;
    localparam int unsigned OUT_W   = 10;

    // Slot counter
    logic [TAG_W-1:0]   in_slot_q, in_slot_d;
    logic [TAG_W-1:0]   tag_c;

    // Stage 1: detuned, octave-shifted frequency
    logic               s1_vld_q, s1_vld_d;
    logic [S1_W-1:0]    s1_q, s1_d;
    logic [3:0]         s1_multi_q, s1_multi_d;
    logic               s1_kon_q, s1_kon_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

    // Stage 2: phase increment after the multiple
    logic               s2_vld_q, s2_vld_d;
    logic [PHASE_W-1:0] s2_inc_q, s2_inc_d;
    logic               s2_kon_q, s2_kon_d;
    logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

    // Stage 3: accumulator memory and registered outputs
    logic [PHASE_W-1:0] phase_mem_q [SLOTS];
    logic [9:0]         phase_out_q, phase_out_d;
    logic [4:0]         out_slot_q, out_slot_d;
    logic               out_valid_q, out_valid_d;

    logic [SHIFT_W-1:0] shifted_c;
    logic [S1_W-1:0]    base_c;
    logic [S1_W-1:0]    dt_ext_c;
    logic [PHASE_W-1:0] inc_c;
    logic [PHASE_W-1:0] cur_phase_c;
    logic [PHASE_W-1:0] new_phase_c;
    logic               wr_en_c;

    // Datapath and next-state logic; every register holds unless slot_en is high
    always_comb begin
        in_slot_d   = in_slot_q;
        s1_vld_d    = s1_vld_q;
        s1_d        = s1_q;
        s1_multi_d  = s1_multi_q;
        s1_kon_d    = s1_kon_q;
        s1_tag_d    = s1_tag_q;
        s2_vld_d    = s2_vld_q;
        s2_inc_d    = s2_inc_q;
        s2_kon_d    = s2_kon_q;
        s2_tag_d    = s2_tag_q;
        phase_out_d = phase_out_q;
        out_slot_d  = out_slot_q;
        out_valid_d = out_valid_q;

        tag_c     = sync ? '0 : in_slot_q;
        shifted_c = SHIFT_W'(fnum_lfo) << block;
        base_c    = S1_W'(shifted_c >> 2);
        dt_ext_c  = {{(S1_W-6){dt_delta[5]}}, dt_delta};

        // multi==0 means a half multiple rather than a zero increment
        if (s1_multi_q == 4'd0) begin
            inc_c = PHASE_W'(s1_q >> 1);
        end else begin
            inc_c = PHASE_W'(s1_q) * PHASE_W'(s1_multi_q);
        end

        cur_phase_c = phase_mem_q[s2_tag_q];
        new_phase_c = s2_kon_q ? '0 : cur_phase_c + s2_inc_q;
        wr_en_c     = slot_en && s2_vld_q;

        if (slot_en) begin
            in_slot_d  = (tag_c == TAG_W'(SLOTS - 1)) ? '0 : tag_c + TAG_W'(1);

            s1_vld_d   = 1'b1;
            s1_d       = base_c + dt_ext_c;
            s1_multi_d = multi;
            s1_kon_d   = kon;
            s1_tag_d   = tag_c;

            s2_vld_d   = s1_vld_q;
            s2_inc_d   = inc_c;
            s2_kon_d   = s1_kon_q;
            s2_tag_d   = s1_tag_q;

            out_valid_d = s2_vld_q;
            if (s2_vld_q) begin
                phase_out_d = new_phase_c[PHASE_W-1 -: OUT_W];
                out_slot_d  = s2_tag_q;
            end
        end
    end

    // Pipeline and output registers
    always_ff @(posedge MCLK) begin
        if (IC) begin
            in_slot_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_q        <= '0;
            s1_multi_q  <= '0;
            s1_kon_q    <= 1'b0;
            s1_tag_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_inc_q    <= '0;
            s2_kon_q    <= 1'b0;
            s2_tag_q    <= '0;
            phase_out_q <= '0;
            out_slot_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            in_slot_q   <= in_slot_d;
            s1_vld_q    <= s1_vld_d;
            s1_q        <= s1_d;
            s1_multi_q  <= s1_multi_d;
            s1_kon_q    <= s1_kon_d;
            s1_tag_q    <= s1_tag_d;
            s2_vld_q    <= s2_vld_d;
            s2_inc_q    <= s2_inc_d;
            s2_kon_q    <= s2_kon_d;
            s2_tag_q    <= s2_tag_d;
            phase_out_q <= phase_out_d;
            out_slot_q  <= out_slot_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Phase memory: one entry written per enabled step
    always_ff @(posedge MCLK) begin
        if (IC) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                phase_mem_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            phase_mem_q[s2_tag_q] <= new_phase_c;
        end
    end

    assign phase_out = phase_out_q;
    assign out_slot  = out_slot_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ym3438_pg_accum.sv
// Scoreboard bench for ym3438_pg_accum: a plain-arithmetic phase model queues expected
// outputs per enabled step; an independent monitor checks every enabled edge.
module tb_ym3438_pg_accum;

    typedef struct packed {
        logic [9:0] ph;
        logic [4:0] sl;
    } exp_t;

    logic        MCLK = 1'b0;
    logic        IC = 1'b1;
    logic        slot_en = 1'b0;
    logic        sync = 1'b0;
    logic [11:0] fnum_lfo = '0;
    logic [2:0]  block = '0;
    logic [5:0]  dt_delta = '0;
    logic [3:0]  multi = '0;
    logic        kon = 1'b0;
    logic [9:0]  phase_out;
    logic [4:0]  out_slot;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   m_phase[24];
    int   m_slot = 0;

    ym3438_pg_accum dut (
        .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .sync(sync),
        .fnum_lfo(fnum_lfo), .block(block), .dt_delta(dt_delta),
        .multi(multi), .kon(kon),
        .phase_out(phase_out), .out_slot(out_slot), .out_valid(out_valid)
    );

    always #5 MCLK = ~MCLK;

    // Increment from the frequency rules using ordinary integer arithmetic
    function automatic int calc_inc(int f, int b, int d, int m);
        int base, dv, s1;
        base = (f * (1 << b)) / 4;
        dv   = (d >= 32) ? d - 64 : d;
        s1   = ((base + dv) % 131072 + 131072) % 131072;
        if (m == 0) return s1 / 2;
        return (s1 * m) % 1048576;
    endfunction

    function automatic void model_issue(bit sy, int f, int b, int d, int m, bit k);
        int tag;
        exp_t e;
        tag    = sy ? 0 : m_slot;
        m_slot = (tag == 23) ? 0 : tag + 1;
        if (k) m_phase[tag] = 0;
        else   m_phase[tag] = (m_phase[tag] + calc_inc(f, b, d, m)) % 1048576;
        e.ph = 10'(m_phase[tag] / 1024);
        e.sl = 5'(tag);
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit en, input bit sy, input int f, input int b,
                        input int d, input int m, input bit k);
        @(negedge MCLK);
        IC       = 1'b0;
        slot_en  = en;
        sync     = sy;
        fnum_lfo = 12'(f);
        block    = 3'(b);
        dt_delta = 6'(d);
        multi    = 4'(m);
        kon      = k;
        if (en) model_issue(sy, f, b, d, m, k);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge MCLK);
            IC       = 1'b1;
            slot_en  = 1'($urandom_range(0, 1));
            sync     = 1'($urandom_range(0, 1));
            fnum_lfo = 12'($urandom);
            kon      = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        for (int i = 0; i < 24; i++) m_phase[i] = 0;
        m_slot = 0;
    endtask

    task automatic rand_step(input int en_pct, input int sync_pct, input int kon_pct);
        step(($urandom_range(0, 99) < en_pct), ($urandom_range(0, 99) < sync_pct),
             int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
             ($urandom_range(0, 99) < kon_pct));
    endtask

    // Monitor: checks outputs after every edge, independent of the stimulus process
    initial begin
        int   en_cnt;
        exp_t last, e;
        bit   last_v;
        bit   en_s, rst_s;
        en_cnt = 0;
        last   = '0;
        last_v = 1'b0;
        forever begin
            @(posedge MCLK);
            en_s  = slot_en;
            rst_s = IC;
            #1;
            if (rst_s) begin
                checks++;
                if (phase_out !== 10'd0 || out_slot !== 5'd0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset: phase_out=%h out_slot=%0d out_valid=%b, required 0/0/0",
                             phase_out, out_slot, out_valid);
                end
                en_cnt = 0;
                last   = '0;
                last_v = 1'b0;
            end else if (en_s) begin
                en_cnt++;
                checks++;
                if (en_cnt >= 3) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_empty: out_valid=%b phase_out=%h slot=%0d, no expected entry",
                                 out_valid, phase_out, out_slot);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_valid !== 1'b1 || phase_out !== e.ph || out_slot !== e.sl) begin
                            errors++;
                            $display("FAIL update: valid=%b phase_out=%h slot=%0d, required valid=1 phase_out=%h slot=%0d",
                                     out_valid, phase_out, out_slot, e.ph, e.sl);
                        end
                        last   = e;
                        last_v = 1'b1;
                    end
                end else if (out_valid !== 1'b0 || phase_out !== last.ph || out_slot !== last.sl) begin
                    errors++;
                    $display("FAIL fill: valid=%b phase_out=%h slot=%0d, required valid=0 phase_out=%h slot=%0d",
                             out_valid, phase_out, out_slot, last.ph, last.sl);
                end
            end else begin
                checks++;
                if (out_valid !== last_v || phase_out !== last.ph || out_slot !== last.sl) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b phase_out=%h slot=%0d, required valid=%b phase_out=%h slot=%0d",
                             out_valid, phase_out, out_slot, last_v, last.ph, last.sl);
                end
            end
        end
    end

    initial begin
        do_reset(3);

        // Zero increment for a full frame keeps every slot at 0
        for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 0, 1, 0);

        // inc = 0x1000 on all slots: 256 rounds wrap the 20-bit phase; key-on slot 5 in round 10
        for (int r = 0; r < 256; r++) begin
            for (int s = 0; s < 24; s++) begin
                step(1, 0, 'h400, 4, 0, 1, (r == 10 && m_slot == 5));
            end
        end

        // Multiple 0 and 15, then the negative-detune wrap case
        for (int s = 0; s < 24; s++) step(1, 0, 'h400, 4, 0, 0, 0);
        for (int s = 0; s < 24; s++) step(1, 0, 'h400, 4, 0, 15, 0);
        do_reset(1);
        step(1, 0, 4, 1, 6'h3D, 15, 0);
        for (int s = 0; s < 30; s++) step(1, 0, 4, 1, 6'h3D, 15, 0);

        // Stall mid-frame for 7 cycles, then sync at tag 17
        for (int s = 0; s < 5; s++) step(1, 0, 'h400, 4, 0, 1, 0);
        for (int s = 0; s < 7; s++) rand_step(0, 50, 50);
        while (m_slot != 17) step(1, 0, 'h400, 4, 0, 1, 0);
        step(1, 0, 'h400, 4, 0, 1, 0);
        step(1, 1, 'h400, 4, 0, 1, 0);
        for (int s = 0; s < 6; s++) step(1, 0, 'h400, 4, 0, 1, 0);

        // Random traffic with stalls, syncs and key-ons
        for (int i = 0; i < 3000; i++) rand_step(75, 2, 5);

        // Reset with phases in flight, then more random traffic
        do_reset(2);
        for (int i = 0; i < 3000; i++) rand_step(70, 3, 5);

        for (int i = 0; i < 4; i++) step(1, 0, 'h123, 3, 5, 7, 0);
        @(negedge MCLK);
        slot_en = 1'b0;
        @(negedge MCLK);

        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL pending: %0d entries left in scoreboard, required 2", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ym3438_pg_accum.md
# ym3438_pg_accum

Phase generator for the YM3438 core, directly downstream of the LFO stage. It takes the LFO-modulated frequency number (`fnum_lfo`) plus the per-slot block, detune and multiple settings, and forms a 20-bit phase increment. It then updates a 24-slot time-multiplexed phase accumulator and presents the top 10 phase bits per slot to the operator stage.

## Interface
- `SLOTS`, 24, number of time-multiplexed slots; slot counter wraps at `SLOTS`-1.
- `PHASE_W`, 20, accumulator width; increment is truncated to this width.

- `MCLK`  in  1  sole clock; all state changes on rising edge.
- `IC`  in  1  synchronous, active-high reset.
- `slot_en`  in  1  advance one slot this cycle. When low, all state holds.
- `sync`  in  1  sampled only with `slot_en`; forces the slot tagged this step to 0.
- `fnum_lfo`  in  12  LFO-modulated fnum (fnum*2 + PM offset) for the current slot.
- `block`  in  3  octave for the current slot.
- `dt_delta`  in  6  signed detune offset for the current slot (two's complement, -32..+31), supplied by the detune ROM.
- `multi`  in  4  frequency multiple for the current slot.
- `kon`  in  1  key-on event for the current slot; resets that slot's phase.
- `phase_out`  out  10  `phase[19:10]` of the slot just updated.
- `out_slot`  out  5  slot index of `phase_out`.
- `out_valid`  out  1  high when `phase_out` holds a freshly updated slot.

## Operation
- Internal slot counter `in_slot` tags each enabled step.
  - On `slot_en`: the tag is 0 if `sync`, otherwise `in_slot`.
  - The counter then becomes tag+1, wrapping `SLOTS`-1 -> 0.
- Stage 1 (enabled step N):
  - `base = ({5'b0,fnum_lfo} << block) >> 2` (17 bits; max 0x1FFE0, no overflow).
  - `s1 = (base + sign-extended dt_delta) mod 2^17`. Negative results wrap, e.g. 2-3 -> 0x1FFFF.
  - `multi`, `kon` and the slot tag are registered alongside `s1`.
- Stage 2 (step N+1):
  - If `multi`==0: `inc = s1 >> 1`.
  - Otherwise: `inc = (s1 * multi) mod 2^20`.
  - `kon` and the tag are carried forward.
- Stage 3 (step N+2):
  - Let `p = phase_mem[tag]`.
  - New value: 0 if `kon`, else `(p + inc) mod 2^20`.
  - Write the new value back to `phase_mem[tag]`.
  - Register `phase_out` = new value [19:10], `out_slot` = tag, `out_valid` = 1.
- `phase_mem`: 24 x 20-bit registers. Only the entry addressed in stage 3 is written per step.
- Pipeline valid bits propagate with `slot_en`. `out_valid` is high only when stage 3 held a valid entry on that step.

## Timing
- Latency: inputs sampled on enabled edge N -> outputs updated on enabled edge N+2 (3 enabled edges inclusive). Throughput is 1 slot per enabled cycle.
- `slot_en` low: pipeline registers, memory, counter and outputs all hold; `out_valid` holds its value.
- Reset (`IC`=1 on an edge, regardless of `slot_en`), including mid-operation:
  - all 24 phases = 0;
  - `in_slot` = 0;
  - pipeline valid bits = 0;
  - `phase_out` = 0, `out_slot` = 0, `out_valid` = 0.
- First enabled step after reset is slot 0; the first `out_valid` follows 2 enabled edges later.
- `kon` on a slot overrides accumulation for that update only; phase is 0 after that step, and the next update of that slot adds `inc` to 0.
- `sync` mid-frame restarts tagging at 0. Entries already in flight retire under their original tags, so no memory entry is corrupted.
- Same tag in stages 1-3 simultaneously cannot occur unless `SLOTS`<3; `SLOTS` >= 3 is required.

## Test plan
- Reset: pulse `IC` mid-stream with nonzero phases -> next cycle `phase_out`=0, `out_valid`=0, `out_slot`=0; after 24 steps with `inc`=0, all slots still read 0.
- Basic increment: slot 0 with `fnum_lfo`=0x400, `block`=4, `dt_delta`=0, `multi`=1 -> `inc`=0x1000. After 1st update `phase_out`=4; after 256 updates `phase_out`=0 (wrap at 2^20).
- Multiple: same base with `multi`=0 -> `inc`=0x800; with `multi`=15 -> `inc`=0xF000 (`phase_out` 0x3C after one update).
- Detune wrap: `fnum_lfo`=4, `block`=1, `dt_delta`=-3, `multi`=15 -> `s1`=0x1FFFF, `inc`=0xDFFF1, `phase_out`=0x37F after one update.
- Key-on isolation: all slots running with `inc`=0x1000, `kon` on slot 5 -> slot 5 reads 0 that round and 4 the next round; slots 4 and 6 unaffected.
- Stall/sync: drop `slot_en` for 7 cycles mid-frame -> outputs frozen, no slot skipped. Assert `sync` at tag 17 -> next tags run 0,1,2…; slot 17 remains in flight and its update retires under tag 17.
